mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage of the core pipeline plus the MEM/WB pipeline register. Takes the instruction held in the EX/MEM register, waits for the data-memory read response when it is a load, then aligns and sign/zero-extends the load data. Passes the writeback result and exception flags to WB through a valid/allowin handshake. Provides forwarding and load-hazard signals to decode.

## Interface
Parameters:
- XLEN, 32, datapath width
- RF_ADDR_WIDTH, 5, register-file address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pipe_flush  in  1  kill MEM and the WB register contents
- ex_mem_valid  in  1  EX/MEM register holds an instruction ready to advance
- mem_allowin  out  1  stage can accept an instruction this cycle
- wb_allowin  in  1  WB can accept an instruction
- mem_wb_valid  out  1  stage has a finished instruction for WB (combinational)
- mem_pc, mem_inst  in  XLEN  from EX/MEM
- mem_req_rf  in  1  writes the register file
- mem_rf_waddr  in  RF_ADDR_WIDTH  destination register
- mem_alu_res  in  XLEN  ALU result or load address
- mem_is_load  in  1  instruction is a load
- mem_ls_addr_2low  in  2  address bits [1:0]
- mem_l_mask  in  5  one-hot load type: [0] LB, [1] LBU, [2] LH, [3] LHU, [4] LW
- ex2mem_exp_flag, ex2mem_inst_addr_misal, ex2mem_is_illg_inst, ex2mem_is_ecall_inst, ex2mem_is_ebreak_inst  in  1 each  exception flags
- dmem_rvalid  in  1  one-cycle read-response strobe
- dmem_rdata  in  XLEN  read data, valid with dmem_rvalid
- wb_pc, wb_inst  out  XLEN  registered
- wb_req_rf  out  1; wb_rf_waddr  out  RF_ADDR_WIDTH; wb_rf_wdata  out  XLEN  registered
- mem2wb_exp_flag, mem2wb_inst_addr_misal, mem2wb_is_illg_inst, mem2wb_is_ecall_inst, mem2wb_is_ebreak_inst  out  1 each  registered
- mem_fwd_valid  out  1  mem_valid && mem_req_rf && mem_ready_go
- mem_fwd_waddr  out  RF_ADDR_WIDTH; mem_fwd_wdata  out  XLEN  forwarding result
- mem_load_busy  out  1  mem_valid && mem_is_load && !mem_ready_go; decode must stall on a dependency

## Operation
- mem_valid register: cleared on reset or flush; loaded with ex_mem_valid when mem_allowin; otherwise holds.
- An instruction needs data when mem_is_load && !ex2mem_exp_flag. An excepting load issued no request and does not wait.
- mem_ready_go = !needs_data || state==HAVE || (state==WAIT && dmem_rvalid).
- mem_allowin = state!=DROP && (!mem_valid || (mem_ready_go && wb_allowin)).
- mem_wb_valid = mem_valid && mem_ready_go.
- Load FSM:
  - IDLE -> WAIT when a needs-data instruction enters.
  - WAIT + dmem_rvalid + wb_allowin: data used directly. Next state is WAIT if a new load enters in the same cycle, otherwise IDLE.
  - WAIT + dmem_rvalid + !wb_allowin -> HAVE, with dmem_rdata captured in rdata_buf.
  - HAVE + wb_allowin -> WAIT or IDLE, by the same rule as above.
  - Flush in WAIT without dmem_rvalid -> DROP. Flush in WAIT with dmem_rvalid, or flush in HAVE -> IDLE.
  - DROP + dmem_rvalid -> IDLE; the response is discarded.
  - dmem_rvalid in IDLE is ignored.
- Load data selection:
  - Source is rdata_buf in HAVE, otherwise dmem_rdata.
  - Byte = source[8*addr_2low +: 8]. Half = source[16*addr_2low[1] +: 16]; addr_2low[0] is ignored because misalignment traps upstream.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the source through. A zero or non-one-hot mask passes the raw source.
- Result is load data for a non-excepting load, otherwise mem_alu_res. mem_fwd_wdata carries the same value.
- WB register: on reset or flush all outputs become 0. On mem_wb_valid && wb_allowin it loads pc, inst, req_rf, waddr, result and all five flags. Otherwise it holds.

## Timing
- Non-load instruction: one cycle in MEM; WB outputs update on the next edge.
- Load: data-memory response latency is at least 1 cycle after the load enters MEM. With a same-cycle response, the load still occupies one cycle.
- Back-to-back loads are fully pipelined when each response arrives in the load's first MEM cycle.
- A flush has priority over every handshake in the same cycle.
- DROP blocks new entries until the stale response arrives. This guarantees one response per request in order.
- Reset: state IDLE, mem_valid 0, rdata_buf 0, all outputs 0.

## Structure
- Shared defines: XLEN, RF_ADDR_WIDTH, ZEROWORD, FLUSH, the l_mask bit indices, and the FSM state encodings (2-bit: IDLE, WAIT, HAVE, DROP).
- One sub-module: load_align, a combinational unit taking source, addr_2low and l_mask and producing the extended XLEN data.

## Test plan
- ALU op with alu_res 0x1234, wb_allowin=1 -> mem_wb_valid in the same cycle; wb_rf_wdata=0x1234 after one edge.
- LB at addr_2low=3, rdata 0x80FF_FF7F, response 2 cycles later -> mem_load_busy for 2 cycles, then wdata=0xFFFF_FF80. LBU of the same load -> 0x0000_0080.
- LH at addr_2low=2, rdata 0x8001_0000, wb_allowin low for 3 cycles -> state HAVE holds 0x8001_0000, then wdata=0xFFFF_8001.
- Load in WAIT, flush asserted, response 4 cycles later -> mem_allowin=0 until the response, the data is dropped, then state IDLE.
- Load with ex2mem_exp_flag=1 and no response -> passes in 1 cycle with the flag propagated and wdata=alu_res.
- Reset asserted mid-WAIT -> all outputs 0 and state IDLE on the next edge.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, flush polarity, load-mask encodings and load FSM states for the MEM stage.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam logic [XLEN-1:0] ZEROWORD  = '0;
  localparam logic FLUSH                = 1'b1;

  localparam int unsigned L_MASK_W = 5;
  localparam int unsigned L_LB     = 0;
  localparam int unsigned L_LBU    = 1;
  localparam int unsigned L_LH     = 2;
  localparam int unsigned L_LHU    = 3;
  localparam int unsigned L_LW     = 4;

  localparam logic [L_MASK_W-1:0] LM_LB  = L_MASK_W'(1 << L_LB);
  localparam logic [L_MASK_W-1:0] LM_LBU = L_MASK_W'(1 << L_LBU);
  localparam logic [L_MASK_W-1:0] LM_LH  = L_MASK_W'(1 << L_LH);
  localparam logic [L_MASK_W-1:0] LM_LHU = L_MASK_W'(1 << L_LHU);
  localparam logic [L_MASK_W-1:0] LM_LW  = L_MASK_W'(1 << L_LW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HAVE = 2'd2,
    DROP = 2'd3
  } ld_state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Picks the addressed byte/half of a load word and sign- or zero-extends it.
module mem_wb_stage_load_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] src,
  input  logic [1:0]      addr_2low,
  input  logic [4:0]      l_mask,
  output logic [XLEN-1:0] load_data_c
);
  import mem_wb_stage_pkg::LM_LB;
  import mem_wb_stage_pkg::LM_LBU;
  import mem_wb_stage_pkg::LM_LH;
  import mem_wb_stage_pkg::LM_LHU;
  import mem_wb_stage_pkg::LM_LW;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // addr_2low[0] is ignored for halves: misaligned halves trap before MEM
  always_comb begin
    byte_sel    = src[{addr_2low, 3'b000} +: 8];
    half_sel    = src[{addr_2low[1], 4'b0000} +: 16];
    load_data_c = src;
    case (l_mask)
      LM_LB:   load_data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LM_LBU:  load_data_c = {{(XLEN-8){1'b0}}, byte_sel};
      LM_LH:   load_data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      LM_LHU:  load_data_c = {{(XLEN-16){1'b0}}, half_sel};
      LM_LW:   load_data_c = src;
      default: load_data_c = src;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: waits for load responses, aligns load data and holds the MEM/WB register.
module mem_wb_stage #(
  parameter int unsigned XLEN          = mem_wb_stage_pkg::XLEN,
  parameter int unsigned RF_ADDR_WIDTH = mem_wb_stage_pkg::RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  input  logic                     ex_mem_valid,
  output logic                     mem_allowin,
  input  logic                     wb_allowin,
  output logic                     mem_wb_valid,
  input  logic [XLEN-1:0]          mem_pc,
  input  logic [XLEN-1:0]          mem_inst,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_is_load,
  input  logic [1:0]               mem_ls_addr_2low,
  input  logic [4:0]               mem_l_mask,
  input  logic                     ex2mem_exp_flag,
  input  logic                     ex2mem_inst_addr_misal,
  input  logic                     ex2mem_is_illg_inst,
  input  logic                     ex2mem_is_ecall_inst,
  input  logic                     ex2mem_is_ebreak_inst,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic [XLEN-1:0]          wb_pc,
  output logic [XLEN-1:0]          wb_inst,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_rf_wdata,
  output logic                     mem2wb_exp_flag,
  output logic                     mem2wb_inst_addr_misal,
  output logic                     mem2wb_is_illg_inst,
  output logic                     mem2wb_is_ecall_inst,
  output logic                     mem2wb_is_ebreak_inst,
  output logic                     mem_fwd_valid,
  output logic [RF_ADDR_WIDTH-1:0] mem_fwd_waddr,
  output logic [XLEN-1:0]          mem_fwd_wdata,
  output logic                     mem_load_busy
);
  import mem_wb_stage_pkg::ld_state_e;
  import mem_wb_stage_pkg::IDLE;
  import mem_wb_stage_pkg::WAIT;
  import mem_wb_stage_pkg::HAVE;
  import mem_wb_stage_pkg::DROP;
  import mem_wb_stage_pkg::FLUSH;

  ld_state_e       state_q, state_d;
  logic            mem_valid_q;
  logic [XLEN-1:0] rdata_buf_q;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] mem_result;
  logic            flush, needs_data, mem_ready_go, enter_load;

  // An excepting load never issued a request, so it must not wait for one
  assign flush        = (pipe_flush == FLUSH);
  assign needs_data   = mem_is_load && !ex2mem_exp_flag;
  assign mem_ready_go = !needs_data || (state_q == HAVE) || ((state_q == WAIT) && dmem_rvalid);
  assign mem_allowin  = (state_q != DROP) && (!mem_valid_q || (mem_ready_go && wb_allowin));
  assign mem_wb_valid = mem_valid_q && mem_ready_go;
  assign enter_load   = ex_mem_valid && mem_allowin && needs_data;

  assign mem_fwd_valid = mem_valid_q && mem_req_rf && mem_ready_go;
  assign mem_fwd_waddr = mem_rf_waddr;
  assign mem_fwd_wdata = mem_result;
  assign mem_load_busy = mem_valid_q && mem_is_load && !mem_ready_go;

  assign load_src   = (state_q == HAVE) ? rdata_buf_q : dmem_rdata;
  assign mem_result = needs_data ? load_data_c : mem_alu_res;

  mem_wb_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .src         (load_src),
    .addr_2low   (mem_ls_addr_2low),
    .l_mask      (mem_l_mask),
    .load_data_c (load_data_c)
  );

  // Load FSM next state; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    if (flush) begin
      case (state_q)
        WAIT:    state_d = dmem_rvalid ? IDLE : DROP;
        HAVE:    state_d = IDLE;
        DROP:    state_d = dmem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (enter_load) state_d = WAIT;
        WAIT: begin
          if (dmem_rvalid) state_d = wb_allowin ? (enter_load ? WAIT : IDLE) : HAVE;
        end
        HAVE: if (wb_allowin) state_d = enter_load ? WAIT : IDLE;
        DROP: if (dmem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      rdata_buf_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush)            mem_valid_q <= 1'b0;
      else if (mem_allowin) mem_valid_q <= ex_mem_valid;
      if (!flush && (state_q == WAIT) && dmem_rvalid && !wb_allowin) rdata_buf_q <= dmem_rdata;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wb_pc                  <= '0;
      wb_inst                <= '0;
      wb_req_rf              <= 1'b0;
      wb_rf_waddr            <= '0;
      wb_rf_wdata            <= '0;
      mem2wb_exp_flag        <= 1'b0;
      mem2wb_inst_addr_misal <= 1'b0;
      mem2wb_is_illg_inst    <= 1'b0;
      mem2wb_is_ecall_inst   <= 1'b0;
      mem2wb_is_ebreak_inst  <= 1'b0;
    end else if (mem_wb_valid && wb_allowin) begin
      wb_pc                  <= mem_pc;
      wb_inst                <= mem_inst;
      wb_req_rf              <= mem_req_rf;
      wb_rf_waddr            <= mem_rf_waddr;
      wb_rf_wdata            <= mem_result;
      mem2wb_exp_flag        <= ex2mem_exp_flag;
      mem2wb_inst_addr_misal <= ex2mem_inst_addr_misal;
      mem2wb_is_illg_inst    <= ex2mem_is_illg_inst;
      mem2wb_is_ecall_inst   <= ex2mem_is_ecall_inst;
      mem2wb_is_ebreak_inst  <= ex2mem_is_ebreak_inst;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage against a transaction-level load/extend model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, pipe_flush, ex_mem_valid, wb_allowin;
  logic        mem_allowin, mem_wb_valid;
  logic [31:0] mem_pc, mem_inst, mem_alu_res, dmem_rdata;
  logic        mem_req_rf, mem_is_load, dmem_rvalid;
  logic [4:0]  mem_rf_waddr, mem_l_mask;
  logic [1:0]  mem_ls_addr_2low;
  logic        ex2mem_exp_flag, ex2mem_inst_addr_misal, ex2mem_is_illg_inst;
  logic        ex2mem_is_ecall_inst, ex2mem_is_ebreak_inst;
  logic [31:0] wb_pc, wb_inst, wb_rf_wdata, mem_fwd_wdata;
  logic        wb_req_rf, mem_fwd_valid, mem_load_busy;
  logic [4:0]  wb_rf_waddr, mem_fwd_waddr;
  logic        mem2wb_exp_flag, mem2wb_inst_addr_misal, mem2wb_is_illg_inst;
  logic        mem2wb_is_ecall_inst, mem2wb_is_ebreak_inst;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .ex_mem_valid(ex_mem_valid),
    .mem_allowin(mem_allowin), .wb_allowin(wb_allowin), .mem_wb_valid(mem_wb_valid),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_req_rf(mem_req_rf), .mem_rf_waddr(mem_rf_waddr),
    .mem_alu_res(mem_alu_res), .mem_is_load(mem_is_load), .mem_ls_addr_2low(mem_ls_addr_2low),
    .mem_l_mask(mem_l_mask), .ex2mem_exp_flag(ex2mem_exp_flag),
    .ex2mem_inst_addr_misal(ex2mem_inst_addr_misal), .ex2mem_is_illg_inst(ex2mem_is_illg_inst),
    .ex2mem_is_ecall_inst(ex2mem_is_ecall_inst), .ex2mem_is_ebreak_inst(ex2mem_is_ebreak_inst),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_req_rf(wb_req_rf), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .mem2wb_exp_flag(mem2wb_exp_flag), .mem2wb_inst_addr_misal(mem2wb_inst_addr_misal),
    .mem2wb_is_illg_inst(mem2wb_is_illg_inst), .mem2wb_is_ecall_inst(mem2wb_is_ecall_inst),
    .mem2wb_is_ebreak_inst(mem2wb_is_ebreak_inst), .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata), .mem_load_busy(mem_load_busy)
  );

  // Reference: kind 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, anything else raw word
  function automatic logic [31:0] ref_load(logic [31:0] src, int addr, int kind);
    logic [31:0] b, h;
    b = (src >> (8 * addr)) & 32'hFF;
    h = (src >> (16 * (addr / 2))) & 32'hFFFF;
    case (kind)
      0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      1: return b;
      2: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3: return h;
      default: return src;
    endcase
  endfunction

  function automatic logic [4:0] kind_mask(int kind);
    return (kind < 5) ? 5'(1 << kind) : 5'd0;
  endfunction

  task automatic clear_inputs();
    pipe_flush = 0; ex_mem_valid = 0; wb_allowin = 1; mem_pc = 0; mem_inst = 0;
    mem_req_rf = 0; mem_rf_waddr = 0; mem_alu_res = 0; mem_is_load = 0;
    mem_ls_addr_2low = 0; mem_l_mask = 0; ex2mem_exp_flag = 0; ex2mem_inst_addr_misal = 0;
    ex2mem_is_illg_inst = 0; ex2mem_is_ecall_inst = 0; ex2mem_is_ebreak_inst = 0;
    dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Drives one load: response d cycles after entry, then s cycles of WB back-pressure
  task automatic do_load(input logic [4:0] mask, input logic [1:0] addr, input logic [31:0] rdata,
                         input int d, input int s, output int busy, output int hold_bad,
                         output logic [31:0] fwd, output logic [31:0] wbd);
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 1; mem_l_mask = mask; mem_ls_addr_2low = addr;
    mem_alu_res = $urandom; mem_req_rf = 1; mem_rf_waddr = 5'($urandom);
    ex2mem_exp_flag = 0; wb_allowin = 1; dmem_rvalid = 0;
    @(negedge clk);
    ex_mem_valid = 0; busy = 0; hold_bad = 0;
    for (int c = 0; c < d; c++) begin
      #1;
      if (mem_load_busy) busy++;
      if (mem_wb_valid) hold_bad++;
      @(negedge clk);
    end
    dmem_rvalid = 1; dmem_rdata = rdata; wb_allowin = (s == 0);
    #1;
    fwd = mem_fwd_wdata;
    if (!mem_wb_valid || mem_load_busy) hold_bad++;
    for (int c = 0; c < s; c++) begin
      @(negedge clk);
      dmem_rvalid = 0; dmem_rdata = $urandom; wb_allowin = (c == s - 1);
      #1;
      if (!mem_wb_valid || mem_fwd_wdata !== fwd) hold_bad++;
    end
    @(negedge clk);
    dmem_rvalid = 0; wb_allowin = 1;
    #1;
    wbd = wb_rf_wdata;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (wb_rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", wb_rf_wdata); end
    vectors++; if (wb_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", wb_pc); end
    vectors++; if (mem_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbvalid got %b want 0", mem_wb_valid); end
    vectors++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", mem_allowin); end
    rst_n = 1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 0; mem_alu_res = 32'h1234; mem_req_rf = 1;
    mem_rf_waddr = 5'd7; mem_pc = 32'h100; mem_inst = 32'h0000_0013;
    @(negedge clk);
    ex_mem_valid = 0;
    #1;
    vectors++; if (mem_wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wbvalid got %b want 1", mem_wb_valid); end
    vectors++; if (mem_fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwdvalid got %b want 1", mem_fwd_valid); end
    vectors++; if (mem_fwd_wdata !== 32'h1234) begin errors++; $display("FAIL alu_fwddata got %h want 1234", mem_fwd_wdata); end
    @(negedge clk);
    #1;
    vectors++; if (wb_rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h want 1234", wb_rf_wdata); end
    vectors++; if (wb_pc !== 32'h100) begin errors++; $display("FAIL alu_pc got %h want 100", wb_pc); end
    vectors++; if (wb_rf_waddr !== 5'd7 || wb_req_rf !== 1'b1) begin errors++; $display("FAIL alu_waddr got %0d/%b want 7/1", wb_rf_waddr, wb_req_rf); end
    vectors++; if (mem_wb_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", mem_wb_valid); end
  endtask

  task automatic test_lb();
    int busy, bad;
    logic [31:0] fwd, wbd;
    do_load(kind_mask(0), 2'd3, 32'h80FF_FF7F, 2, 0, busy, bad, fwd, wbd);
    vectors++; if (busy !== 2) begin errors++; $display("FAIL lb_busy got %0d want 2", busy); end
    vectors++; if (bad !== 0) begin errors++; $display("FAIL lb_hold got %0d want 0", bad); end
    vectors++; if (wbd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata got %h want ffffff80", wbd); end
    do_load(kind_mask(1), 2'd3, 32'h80FF_FF7F, 2, 0, busy, bad, fwd, wbd);
    vectors++; if (wbd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_wdata got %h want 00000080", wbd); end
  endtask

  task automatic test_have();
    int busy, bad;
    logic [31:0] fwd, wbd;
    do_load(kind_mask(2), 2'd2, 32'h8001_0000, 1, 3, busy, bad, fwd, wbd);
    vectors++; if (bad !== 0) begin errors++; $display("FAIL lh_have_hold got %0d want 0", bad); end
    vectors++; if (fwd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_fwd got %h want ffff8001", fwd); end
    vectors++; if (wbd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_wdata got %h want ffff8001", wbd); end
  endtask

  task automatic test_exc_load();
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 1; mem_l_mask = kind_mask(4); ex2mem_exp_flag = 1;
    ex2mem_is_ecall_inst = 1; mem_alu_res = 32'hDEAD_0004; dmem_rvalid = 0;
    @(negedge clk);
    ex_mem_valid = 0;
    #1;
    vectors++; if (mem_wb_valid !== 1'b1 || mem_load_busy !== 1'b0) begin errors++; $display("FAIL exc_pass got %b/%b want 1/0", mem_wb_valid, mem_load_busy); end
    @(negedge clk);
    #1;
    vectors++; if (mem2wb_exp_flag !== 1'b1 || mem2wb_is_ecall_inst !== 1'b1) begin errors++; $display("FAIL exc_flags got %b/%b want 1/1", mem2wb_exp_flag, mem2wb_is_ecall_inst); end
    vectors++; if (wb_rf_wdata !== 32'hDEAD_0004) begin errors++; $display("FAIL exc_wdata got %h want dead0004", wb_rf_wdata); end
    ex2mem_exp_flag = 0; ex2mem_is_ecall_inst = 0;
  endtask

  task automatic test_flush_drop();
    int blocked;
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 1; mem_l_mask = kind_mask(4); mem_req_rf = 1;
    @(negedge clk);
    ex_mem_valid = 0; pipe_flush = 1;
    @(negedge clk);
    pipe_flush = 0; ex_mem_valid = 1; mem_is_load = 0; mem_alu_res = 32'h777;
    blocked = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_rvalid = (i == 3); dmem_rdata = 32'hBAD0_BAD0;
      #1;
      if (mem_allowin === 1'b0 && mem_wb_valid === 1'b0) blocked++;
      @(negedge clk);
    end
    dmem_rvalid = 0;
    #1;
    vectors++; if (blocked !== 4) begin errors++; $display("FAIL drop_block got %0d want 4", blocked); end
    vectors++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL drop_release got %b want 1", mem_allowin); end
    vectors++; if (wb_rf_wdata !== 32'd0) begin errors++; $display("FAIL drop_wbclear got %h want 0", wb_rf_wdata); end
    @(negedge clk);
    ex_mem_valid = 0;
    #1;
    vectors++; if (mem_wb_valid !== 1'b1 || mem_fwd_wdata !== 32'h777) begin errors++; $display("FAIL drop_next got %b/%h want 1/777", mem_wb_valid, mem_fwd_wdata); end
    @(negedge clk);
    #1;
    vectors++; if (wb_rf_wdata !== 32'h777) begin errors++; $display("FAIL drop_nextwb got %h want 777", wb_rf_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [6];
    int bad = 0;
    int n = 6;
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 1; mem_l_mask = kind_mask(4); mem_ls_addr_2low = 0;
    wb_allowin = 1; dmem_rvalid = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data[i] = $urandom;
      dmem_rvalid = 1; dmem_rdata = data[i]; ex_mem_valid = (i < n - 1);
      #1;
      if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b1 || mem_fwd_wdata !== data[i]) bad++;
      if (i > 0 && wb_rf_wdata !== data[i-1]) bad++;
    end
    @(negedge clk);
    dmem_rvalid = 0;
    #1;
    vectors++; if (bad !== 0) begin errors++; $display("FAIL b2b_stream got %0d bad cycles want 0", bad); end
    vectors++; if (wb_rf_wdata !== data[n-1]) begin errors++; $display("FAIL b2b_last got %h want %h", wb_rf_wdata, data[n-1]); end
  endtask

  task automatic test_random();
    int busy, bad, kind, d, s, addr;
    logic [31:0] rdata, exp, fwd, wbd;
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 5)); addr = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3)); s = int'($urandom_range(0, 3)); rdata = $urandom;
      exp = ref_load(rdata, addr, kind);
      do_load(kind_mask(kind), 2'(addr), rdata, d, s, busy, bad, fwd, wbd);
      vectors++; if (busy !== d) begin errors++; $display("FAIL rnd%0d_busy got %0d want %0d", n, busy, d); end
      vectors++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_hold got %0d want 0", n, bad); end
      vectors++; if (fwd !== exp) begin errors++; $display("FAIL rnd%0d_fwd got %h want %h", n, fwd, exp); end
      vectors++; if (wbd !== exp) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, wbd, exp); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int busy, bad;
    logic [31:0] fwd, wbd;
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 0; mem_alu_res = 32'hCAFE; mem_req_rf = 1; mem_pc = 32'h200;
    @(negedge clk);
    ex_mem_valid = 1; mem_is_load = 1; mem_l_mask = kind_mask(4);
    @(negedge clk);
    ex_mem_valid = 0;
    #1;
    vectors++; if (mem_load_busy !== 1'b1) begin errors++; $display("FAIL rstw_busy got %b want 1", mem_load_busy); end
    rst_n = 0;
    @(negedge clk);
    #1;
    vectors++; if (wb_rf_wdata !== 32'd0 || wb_pc !== 32'd0 || wb_req_rf !== 1'b0) begin errors++; $display("FAIL rstw_wb got %h/%h/%b want 0/0/0", wb_rf_wdata, wb_pc, wb_req_rf); end
    vectors++; if (mem_wb_valid !== 1'b0 || mem_load_busy !== 1'b0) begin errors++; $display("FAIL rstw_ctl got %b/%b want 0/0", mem_wb_valid, mem_load_busy); end
    rst_n = 1;
    do_load(kind_mask(4), 2'd0, 32'h5A5A_1234, 0, 1, busy, bad, fwd, wbd);
    vectors++; if (wbd !== 32'h5A5A_1234 || bad !== 0) begin errors++; $display("FAIL rstw_after got %h/%0d want 5a5a1234/0", wbd, bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_have();
    test_exc_load();
    test_flush_drop();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
